fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_pkg.sv | 18 +
 rtl/fetch_ring.sv | 34 +++
 rtl/fetch_buffer.sv | 178 +++++++++++++++++
 tb/tb_fetch_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared types and sizing for the instruction fetch buffer.
package fetch_buffer_pkg;
    localparam int FB_BUF_BYTES  = 128;
    localparam int FB_LINE_BYTES = 64;
    localparam int FB_WIN_BYTES  = 15;
    localparam int FB_BEAT_BYTES = 8;

    localparam logic [1:0]  TAG_READ   = 2'b01;
    localparam logic [2:0]  TAG_MEMORY = 3'b010;
    localparam logic [12:0] REQ_TAG    = {TAG_READ, TAG_MEMORY, 8'h00};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACTIVE
    } fb_state_e;
endpackage

// File: rtl/fetch_ring.sv
// Byte ring: one aligned 8-byte write per cycle, a wrapped WIN_BYTES read window.
module fetch_ring
    import fetch_buffer_pkg::*;
#(
    parameter int BUF_BYTES = FB_BUF_BYTES,
    parameter int WIN_BYTES = FB_WIN_BYTES
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(BUF_BYTES)-1:0] wr_off,
    input  logic [63:0]              wr_data,
    input  logic [$clog2(BUF_BYTES)-1:0] rd_off,
    output logic [8*WIN_BYTES-1:0]   rd_bytes
);
    localparam int OFF_W = $clog2(BUF_BYTES);

    logic [7:0] mem_q [BUF_BYTES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < FB_BEAT_BYTES; i++) begin
                mem_q[wr_off + OFF_W'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

    // Offset arithmetic is modulo the ring size, so the window wraps for free.
    always_comb begin
        rd_bytes = '0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            rd_bytes[8*k +: 8] = mem_q[rd_off + OFF_W'(k)];
        end
    end
endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: requests whole lines, stores beats in a byte ring and
// presents a decode window at the current decode address.
//   state    | meaning
//   S_IDLE   | waiting for room for one more line
//   S_REQ    | reqcyc high, waiting for reqack
//   S_WAIT   | request accepted, waiting for first beat
//   S_ACTIVE | receiving remaining beats of the line
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int BUF_BYTES  = FB_BUF_BYTES,
    parameter int LINE_BYTES = FB_LINE_BYTES,
    parameter int WIN_BYTES  = FB_WIN_BYTES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [63:0]            entry,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_addr,
    output logic                   reqcyc,
    output logic [63:0]            req,
    output logic [12:0]            reqtag,
    input  logic                   reqack,
    input  logic                   respcyc,
    input  logic [63:0]            resp,
    output logic                   respack,
    output logic                   win_valid,
    output logic [8*WIN_BYTES-1:0] win_bytes,
    output logic [63:0]            win_addr,
    input  logic [3:0]             consume,
    output logic                   protocol_err
);
    localparam int OFF_W  = $clog2(BUF_BYTES);
    localparam int OCC_W  = OFF_W + 2;
    localparam int BEATS  = LINE_BYTES / FB_BEAT_BYTES;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LINE_W = $clog2(LINE_BYTES);
    localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);
    localparam logic signed [OCC_W-1:0] REQ_LIMIT = OCC_W'(BUF_BYTES - LINE_BYTES);
    localparam logic signed [OCC_W-1:0] WIN_LIMIT = OCC_W'(WIN_BYTES);
    localparam logic signed [OCC_W-1:0] BEAT_INC  = OCC_W'(FB_BEAT_BYTES);

    fb_state_e state_q, state_d;
    logic [63:0] fetch_rip_q, fetch_rip_d, win_addr_q, win_addr_d, req_q, req_d;
    logic [BEAT_W-1:0] skip_q, skip_d, beat_q, beat_d;
    logic [OFF_W-1:0] fetch_off_q, fetch_off_d, dec_off_q, dec_off_d;
    logic signed [OCC_W-1:0] occ_q, occ_d, occ_add, occ_sub, entry_occ, redir_occ;
    logic [12:0] reqtag_q, reqtag_d;
    logic discard_q, discard_d, protocol_err_q, protocol_err_d;
    logic reqcyc_q, reqcyc_d, win_valid_q, win_valid_d;
    logic beat_in, last_beat, wr_en;

    // Occupancy starts negative by the start byte offset: the first written beat
    // lands at ring 0 while decode begins at start[2:0] inside it.
    assign entry_occ = -$signed(OCC_W'(entry[2:0]));
    assign redir_occ = -$signed(OCC_W'(redirect_addr[2:0]));

    always_comb begin
        state_d        = state_q;
        fetch_rip_d    = fetch_rip_q;
        skip_d         = skip_q;
        beat_d         = beat_q;
        fetch_off_d    = fetch_off_q;
        dec_off_d      = dec_off_q;
        occ_d          = occ_q;
        win_addr_d     = win_addr_q;
        discard_d      = discard_q;
        protocol_err_d = protocol_err_q;
        occ_add        = '0;
        occ_sub        = '0;
        wr_en          = 1'b0;
        beat_in        = respcyc && (state_q == S_WAIT || state_q == S_ACTIVE);
        last_beat      = beat_in && (beat_q == BEAT_W'(BEATS - 1));

        if ((respcyc && !beat_in) || (reqack && state_q != S_REQ)) protocol_err_d = 1'b1;

        case (state_q)
            S_IDLE:   if (occ_q <= REQ_LIMIT) state_d = S_REQ;
            S_REQ:    if (reqack) state_d = S_WAIT;
            S_WAIT:   if (beat_in) state_d = S_ACTIVE;
            S_ACTIVE: if (last_beat) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (beat_in) beat_d = beat_q + BEAT_W'(1);

        if (redirect_valid) begin
            fetch_rip_d = redirect_addr & LINE_MASK;
            skip_d      = redirect_addr[LINE_W-1:3];
            fetch_off_d = '0;
            dec_off_d   = OFF_W'(redirect_addr[2:0]);
            occ_d       = redir_occ;
            win_addr_d  = redirect_addr;
            // Any line already accepted by the bus must be drained without writing.
            discard_d   = ((state_q == S_WAIT || state_q == S_ACTIVE) && !last_beat)
                        || (state_q == S_REQ && reqack);
        end else begin
            wr_en = beat_in && !discard_q && (beat_q >= skip_q);
            if (wr_en) begin
                fetch_off_d = fetch_off_q + OFF_W'(FB_BEAT_BYTES);
                occ_add     = BEAT_INC;
            end
            if (win_valid_q) begin
                dec_off_d  = dec_off_q + OFF_W'(consume);
                win_addr_d = win_addr_q + 64'(consume);
                occ_sub    = OCC_W'(consume);
            end
            occ_d = occ_q + occ_add - occ_sub;
            if (last_beat) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                end else begin
                    fetch_rip_d = fetch_rip_q + 64'(LINE_BYTES);
                    skip_d      = '0;
                end
            end
        end

        win_valid_d = occ_d >= WIN_LIMIT;
        reqcyc_d    = state_d == S_REQ;
        req_d       = reqcyc_d ? fetch_rip_d : '0;
        reqtag_d    = reqcyc_d ? REQ_TAG : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            fetch_rip_q    <= entry & LINE_MASK;
            skip_q         <= entry[LINE_W-1:3];
            beat_q         <= '0;
            fetch_off_q    <= '0;
            dec_off_q      <= OFF_W'(entry[2:0]);
            occ_q          <= entry_occ;
            win_addr_q     <= entry;
            discard_q      <= 1'b0;
            protocol_err_q <= 1'b0;
            reqcyc_q       <= 1'b0;
            req_q          <= '0;
            reqtag_q       <= '0;
            win_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_rip_q    <= fetch_rip_d;
            skip_q         <= skip_d;
            beat_q         <= beat_d;
            fetch_off_q    <= fetch_off_d;
            dec_off_q      <= dec_off_d;
            occ_q          <= occ_d;
            win_addr_q     <= win_addr_d;
            discard_q      <= discard_d;
            protocol_err_q <= protocol_err_d;
            reqcyc_q       <= reqcyc_d;
            req_q          <= req_d;
            reqtag_q       <= reqtag_d;
            win_valid_q    <= win_valid_d;
        end
    end

    fetch_ring #(
        .BUF_BYTES(BUF_BYTES),
        .WIN_BYTES(WIN_BYTES)
    ) u_ring (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_off  (fetch_off_q),
        .wr_data (resp),
        .rd_off  (dec_off_q),
        .rd_bytes(win_bytes)
    );

    assign reqcyc       = reqcyc_q;
    assign req          = req_q;
    assign reqtag       = reqtag_q;
    assign respack      = respcyc;
    assign win_valid    = win_valid_q;
    assign win_addr     = win_addr_q;
    assign protocol_err = protocol_err_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: line fetches, window/consume table, wrap,
// redirect mid-line, unaligned entry and protocol error.
module tb_fetch_buffer;
    localparam logic [12:0] EXP_TAG = 13'b01_010_0000_0000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [63:0]  entry = 64'h1000;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_addr = '0;
    logic         reqack = 1'b0;
    logic         respcyc = 1'b0;
    logic [63:0]  resp = '0;
    logic [3:0]   consume = '0;
    logic         reqcyc, respack, win_valid, protocol_err;
    logic [63:0]  req, win_addr;
    logic [12:0]  reqtag;
    logic [119:0] win_bytes;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  cons;
        logic        valid;
        logic [63:0] addr;
        logic        reqcyc;
    } vec_t;
    vec_t vecs [11];

    fetch_buffer dut (
        .clk(clk), .reset_n(reset_n), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .reqcyc(reqcyc), .req(req), .reqtag(reqtag), .reqack(reqack),
        .respcyc(respcyc), .resp(resp), .respack(respack),
        .win_valid(win_valid), .win_bytes(win_bytes), .win_addr(win_addr),
        .consume(consume), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = mem_byte(a + 64'(k));
        return d;
    endfunction

    function automatic logic [119:0] exp_win(input logic [63:0] a);
        logic [119:0] w;
        for (int k = 0; k < 15; k++) w[8*k +: 8] = mem_byte(a + 64'(k));
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [63:0] exp_addr, input string name);
        int n = 0;
        while (!reqcyc && n < 50) begin
            tick();
            n++;
        end
        chk({name, " reqcyc"}, reqcyc, 1'b1);
        chk({name, " req"}, req, exp_addr);
        chk({name, " reqtag"}, reqtag, EXP_TAG);
    endtask

    task automatic do_ack(input int delay, input logic [63:0] exp_addr);
        repeat (delay) tick();
        chk("req held", req, exp_addr);
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        chk("reqcyc drop", reqcyc, 1'b0);
    endtask

    task automatic beat(input logic [63:0] a, input logic [3:0] cons,
                        input logic redir, input logic [63:0] raddr);
        respcyc = 1'b1;
        resp = beat_data(a);
        consume = cons;
        redirect_valid = redir;
        redirect_addr = raddr;
        #1;
        chk("respack", respack, 1'b1);
        tick();
        respcyc = 1'b0;
        consume = '0;
        redirect_valid = 1'b0;
    endtask

    task automatic run_line(input logic [63:0] base, input logic [7:0] mask, input string name);
        for (int i = 0; i < 8; i++) begin
            beat(base + 64'(8 * i), 4'd0, 1'b0, 64'h0);
            chk($sformatf("%s beat%0d win_valid", name, i), win_valid, mask[i]);
        end
    endtask

    initial begin
        int seen;
        vecs[0]  = '{4'd15, 1'b1, 64'h100F, 1'b0};
        vecs[1]  = '{4'd0,  1'b1, 64'h100F, 1'b0};
        vecs[2]  = '{4'd7,  1'b1, 64'h1016, 1'b0};
        vecs[3]  = '{4'd8,  1'b1, 64'h101E, 1'b0};
        vecs[4]  = '{4'd15, 1'b1, 64'h102D, 1'b0};
        vecs[5]  = '{4'd15, 1'b1, 64'h103C, 1'b0};
        vecs[6]  = '{4'd15, 1'b1, 64'h104B, 1'b0};
        vecs[7]  = '{4'd15, 1'b1, 64'h105A, 1'b1};
        vecs[8]  = '{4'd15, 1'b1, 64'h1069, 1'b1};
        vecs[9]  = '{4'd15, 1'b0, 64'h1078, 1'b1};
        vecs[10] = '{4'd15, 1'b0, 64'h1078, 1'b1};

        // Reset state with aligned entry
        repeat (3) tick();
        chk("rst reqcyc", reqcyc, 1'b0);
        chk("rst req", req, 64'h0);
        chk("rst reqtag", reqtag, 13'h0);
        chk("rst win_valid", win_valid, 1'b0);
        chk("rst protocol_err", protocol_err, 1'b0);
        chk("rst win_addr", win_addr, 64'h1000);
        chk("rst respack", respack, 1'b0);
        reset_n = 1'b1;

        // Two lines fetched with no consumption, then the ring is full
        wait_req(64'h1000, "line0");
        do_ack(2, 64'h1000);
        run_line(64'h1000, 8'hFE, "line0");
        chk("line0 win_bytes", win_bytes, exp_win(64'h1000));
        chk("line0 win_addr", win_addr, 64'h1000);
        wait_req(64'h1040, "line1");
        do_ack(0, 64'h1040);
        run_line(64'h1040, 8'hFF, "line1");
        seen = 0;
        repeat (20) begin
            tick();
            if (reqcyc) seen++;
        end
        chk("no third line", seen, 0);

        // Consume table; request rises once occupancy drops to 64
        for (int i = 0; i < 11; i++) begin
            consume = vecs[i].cons;
            tick();
            consume = '0;
            chk($sformatf("vec%0d win_valid", i), win_valid, vecs[i].valid);
            chk($sformatf("vec%0d win_addr", i), win_addr, vecs[i].addr);
            chk($sformatf("vec%0d reqcyc", i), reqcyc, vecs[i].reqcyc);
            if (vecs[i].valid) chk($sformatf("vec%0d win_bytes", i), win_bytes, exp_win(vecs[i].addr));
        end

        // dec_off=120: wrapped window, consume during a beat write
        wait_req(64'h1080, "line2");
        do_ack(1, 64'h1080);
        beat(64'h1080, 4'd0, 1'b0, 64'h0);
        chk("wrap win_valid", win_valid, 1'b1);
        chk("wrap win_bytes", win_bytes, exp_win(64'h1078));
        beat(64'h1088, 4'd15, 1'b0, 64'h0);
        chk("wrap consume win_valid", win_valid, 1'b0);
        chk("wrap consume win_addr", win_addr, 64'h1087);
        beat(64'h1090, 4'd0, 1'b0, 64'h0);
        chk("wrap new win_valid", win_valid, 1'b1);
        chk("wrap new win_bytes", win_bytes, exp_win(64'h1087));
        for (int i = 3; i < 8; i++) beat(64'h1080 + 64'(8 * i), 4'd0, 1'b0, 64'h0);

        // Redirect during beat 3 of a line
        wait_req(64'h10C0, "line3");
        do_ack(0, 64'h10C0);
        for (int i = 0; i < 3; i++) beat(64'h10C0 + 64'(8 * i), 4'd0, 1'b0, 64'h0);
        beat(64'h10D8, 4'd0, 1'b1, 64'h2008);
        chk("redir win_valid", win_valid, 1'b0);
        chk("redir win_addr", win_addr, 64'h2008);
        seen = 0;
        for (int i = 4; i < 8; i++) begin
            beat(64'h10C0 + 64'(8 * i), 4'd0, 1'b0, 64'h0);
            if (reqcyc) seen++;
        end
        chk("drain no req", seen, 0);
        chk("drain win_valid", win_valid, 1'b0);
        wait_req(64'h2000, "redir line");
        do_ack(0, 64'h2000);
        run_line(64'h2000, 8'hFC, "redir line");
        chk("redir line win_addr", win_addr, 64'h2008);
        chk("redir line win_bytes", win_bytes, exp_win(64'h2008));
        wait_req(64'h2040, "after redir");
        chk("no err so far", protocol_err, 1'b0);

        // Reset mid-request with unaligned entry
        entry = 64'h1013;
        reset_n = 1'b0;
        #1;
        chk("rst2 reqcyc", reqcyc, 1'b0);
        chk("rst2 win_valid", win_valid, 1'b0);
        chk("rst2 win_addr", win_addr, 64'h1013);
        tick();
        tick();
        reset_n = 1'b1;
        wait_req(64'h1000, "unaligned");
        do_ack(0, 64'h1000);
        run_line(64'h1000, 8'hF0, "unaligned");
        chk("unaligned win_addr", win_addr, 64'h1013);
        chk("unaligned win_bytes", win_bytes, exp_win(64'h1013));

        // Stray beat while IDLE
        chk("pre err", protocol_err, 1'b0);
        respcyc = 1'b1;
        resp = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        respcyc = 1'b0;
        chk("stray protocol_err", protocol_err, 1'b1);
        chk("stray win_valid", win_valid, 1'b1);
        chk("stray win_addr", win_addr, 64'h1013);
        chk("stray win_bytes", win_bytes, exp_win(64'h1013));
        repeat (5) tick();
        chk("err sticky", protocol_err, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("err cleared", protocol_err, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
